// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, S-boxes, key schedule, FSM states.
// Used by both the encryption and decryption cores.
package des_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      OUT   = 2'd2
   } des_state_e;

   localparam int unsigned IP_T [0:63] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

   localparam int unsigned FP_T [0:63] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [0:47] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int unsigned PC1_T [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Row-major: entry index = row*16 + col.
   localparam int unsigned SBOX [0:7][0:63] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   localparam int unsigned LS_T [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Decrypt round n needs C/D of K(17-n): none for K16, then undo the encrypt shift ls[18-n].
   function automatic int unsigned rs_of(input logic [4:0] n);
      if (n < 5'd2 || n > 5'd16) return 0;
      return LS_T[5'd17 - n];
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned amt);
      case (amt)
         0:       return x;
         1:       return {x[0], x[27:1]};
         default: return {x[1:0], x[27:2]};
      endcase
   endfunction

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int unsigned i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int unsigned i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   // DES keys carry odd parity per byte; flag any byte that does not.
   function automatic logic key_parity_err(input logic [63:0] k);
      logic err;
      err = 1'b0;
      for (int unsigned i = 0; i < 8; i++) err = err | ~(^k[8*i +: 8]);
      return err;
   endfunction

endpackage

// File: rtl/des_f_func.sv
// DES Feistel function f(R, K): expansion, key mix, S-box substitution, P permutation.
module des_f_func
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);

   logic [47:0] e_w;
   logic [47:0] x_w;
   logic [31:0] s_w;
   logic [5:0]  six;

   always_comb begin
      e_w = '0;
      for (int unsigned i = 0; i < 48; i++) e_w[47-i] = r_i[32-E_T[i]];
      x_w = e_w ^ k_i;
      s_w = '0;
      six = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         six = x_w[47-6*b -: 6];
         s_w[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
      end
      f_o = '0;
      for (int unsigned i = 0; i < 32; i++) f_o[31-i] = s_w[32-P_T[i]];
   end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative single-DES decryption, one Feistel round per clock, subkeys K16..K1 on the fly.
// Optional key parity flag enabled by defining DES_DEC_PARITY_CHK_EN.
module des_decrypt_core
   import des_pkg::*;
#(
   parameter int unsigned ROUNDS = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] cipher_text,
   input  logic [63:0] key_din,
   output logic [63:0] plain_text,
   output logic        dat_valid,
   output logic        busy
`ifdef DES_DEC_PARITY_CHK_EN
  ,output logic        key_err
`endif
);

   des_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] l_q, r_q, r_d, f_w;
   logic [27:0] c_q, d_q, c_d, d_d;
   logic [47:0] subkey_w;
   logic [63:0] pt_q;
   logic        dv_q, busy_q;
   int unsigned amt_w;

   always_comb begin
      amt_w    = rs_of(cnt_q);
      c_d      = rotr28(c_q, amt_w);
      d_d      = rotr28(d_q, amt_w);
      subkey_w = perm_pc2({c_d, d_d});
      r_d      = l_q ^ f_w;
   end

   des_f_func u_f (
      .r_i (r_q),
      .k_i (subkey_w),
      .f_o (f_w)
   );

`ifdef DES_DEC_PARITY_CHK_EN
   logic kerr_q;
   assign key_err = kerr_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         pt_q    <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef DES_DEC_PARITY_CHK_EN
         kerr_q  <= 1'b0;
`endif
      end else begin
         dv_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               {l_q, r_q} <= perm_ip(cipher_text);
               {c_q, d_q} <= perm_pc1(key_din);
               cnt_q      <= 5'd1;
               busy_q     <= 1'b1;
               state_q    <= ROUND;
`ifdef DES_DEC_PARITY_CHK_EN
               kerr_q     <= key_parity_err(key_din);
`endif
            end
            ROUND: begin
               c_q   <= c_d;
               d_q   <= d_d;
               l_q   <= r_q;
               r_q   <= r_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == ROUNDS[4:0]) state_q <= OUT;
            end
            OUT: begin
               pt_q    <= perm_fp({r_q, l_q});
               dv_q    <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign plain_text = pt_q;
   assign dat_valid  = dv_q;
   assign busy       = busy_q;

endmodule
